// File: rtl/counter_pkg.sv
// =============================================================================
// Module      : counter_pkg
// Description : Shared constants and sizing helper for the up/down counter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((longint'(1) << result) < longint'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_updown_counter_tick_prescaler.sv
// =============================================================================
// Module      : tick_prescaler
// Description : Free-running divider; strobe is high on the last phase of DIV.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic strobe
);

    // DIV=1 keeps a single-bit phase pinned at 0, so strobe is constantly high.
    localparam int              PW     = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [PW-1:0]   C_LAST = PW'(DIV - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = (phase_q == C_LAST) ? '0 : phase_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign strobe = (phase_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/param_updown_counter.sv
// =============================================================================
// Module      : param_updown_counter
// Description : Up/down counter with wrap/saturate, clamped load and optional
//               internal prescaler (enabled by macro COUNTER_PRESCALE_EN).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int PRESCALE = 33554432
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    generate
        if ((MAX < 0) || (longint'(MAX) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_max
            $error("param_updown_counter: MAX out of range for WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("param_updown_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic             w_strobe;
    logic             w_step;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

`ifdef COUNTER_PRESCALE_EN
    tick_prescaler #(
        .DIV (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .strobe (w_strobe)
    );
`else
    assign w_strobe = 1'b1;
`endif

    assign w_step = en & w_strobe;

    // tc defaults low so it can only ever be a single-cycle wrap pulse.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > C_MAX) ? C_MAX : load_val;
        end else if (w_step) begin
            case (dir)
                DIR_UP: begin
                    if (count_q != C_MAX) begin
                        count_d = count_q + WIDTH'(1);
                    end else if (sat == MODE_WRAP) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (sat == MODE_WRAP) begin
                        count_d = C_MAX;
                        tc_d    = 1'b1;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign at_zero = (count_q == '0);
    assign at_max  = (count_q == C_MAX);

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
// =============================================================================
// Module      : tb_param_updown_counter
// Description : Scoreboard bench for param_updown_counter (WIDTH=4, MAX=9,
//               PRESCALE=4); follows COUNTER_PRESCALE_EN like the design.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_param_updown_counter;

    localparam int WIDTH    = 4;
    localparam int MAX      = 9;
    localparam int PRESCALE = 4;
`ifdef COUNTER_PRESCALE_EN
    localparam bit PRE_ON   = 1'b1;
    localparam int SC       = PRESCALE;
`else
    localparam bit PRE_ON   = 1'b0;
    localparam int SC       = 1;
`endif

    typedef struct {
        int   cnt;
        logic tc;
        logic az;
        logic am;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             dir;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_zero;
    logic             at_max;

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    int   m_cnt = 0;
    logic m_tc  = 1'b0;
    int   m_pre = 0;

    always #5 clk = ~clk;

    param_updown_counter #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .at_zero  (at_zero),
        .at_max   (at_max)
    );

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one clock of stimulus, predict the outcome, then compare after the edge.
    task automatic cyc(input logic r, input logic e, input logic d, input logic s,
                       input logic l, input logic [WIDTH-1:0] lv);
        exp_t x;
        exp_t y;
        logic stb;
        rst = r; en = e; dir = d; sat = s; load = l; load_val = lv;
        stb = PRE_ON ? (m_pre == PRESCALE - 1) : 1'b1;
        if (!r) begin
            m_cnt = 0; m_tc = 1'b0; m_pre = 0;
        end else begin
            m_pre = (m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
            m_tc  = 1'b0;
            if (l) begin
                m_cnt = (int'(lv) > MAX) ? MAX : int'(lv);
            end else if (e && stb) begin
                if (d) begin
                    if (m_cnt < MAX)  m_cnt = m_cnt + 1;
                    else if (!s)      begin m_cnt = 0; m_tc = 1'b1; end
                end else begin
                    if (m_cnt > 0)    m_cnt = m_cnt - 1;
                    else if (!s)      begin m_cnt = MAX; m_tc = 1'b1; end
                end
            end
        end
        x.cnt = m_cnt; x.tc = m_tc; x.az = (m_cnt == 0); x.am = (m_cnt == MAX);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk_eq("sb_empty", 0, 1);
        end else begin
            y = sb_q.pop_front();
            chk_eq("count",   int'(count),   y.cnt);
            chk_eq("tc",      int'(tc),      int'(y.tc));
            chk_eq("at_zero", int'(at_zero), int'(y.az));
            chk_eq("at_max",  int'(at_max),  int'(y.am));
        end
    endtask

    task automatic run(input int n, input logic d, input logic s);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, d, s, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; dir = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;

        // Reset held with en and load asserted
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
            chk_eq("rst_count", int'(count), 0);
            chk_eq("rst_tc", int'(tc), 0);
            chk_eq("rst_at_zero", int'(at_zero), 1);
            chk_eq("rst_at_max", int'(at_max), 0);
        end

        // Up wrap: ten steps from 0 end at 0 with the wrap pulse
        run(9 * SC, 1'b1, 1'b0);
        chk_eq("up_at9", int'(count), 9);
        chk_eq("up_atmax9", int'(at_max), 1);
        run(SC, 1'b1, 1'b0);
        chk_eq("up_wrap_count", int'(count), 0);
        chk_eq("up_wrap_tc", int'(tc), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk_eq("up_tc_drop", int'(tc), 0);

        // Down saturate from 2
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        chk_eq("ld2", int'(count), 2);
        run(4 * SC, 1'b0, 1'b1);
        chk_eq("dn_sat_count", int'(count), 0);
        chk_eq("dn_sat_zero", int'(at_zero), 1);
        chk_eq("dn_sat_tc", int'(tc), 0);

        // Down wrap from 0
        run(SC, 1'b0, 1'b0);
        chk_eq("dn_wrap_count", int'(count), 9);
        chk_eq("dn_wrap_tc", int'(tc), 1);

        // Load clamp beats step
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
        chk_eq("clamp_count", int'(count), 9);
        chk_eq("clamp_tc", int'(tc), 0);
        chk_eq("clamp_atmax", int'(at_max), 1);

        // Prescale timing from reset
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
            chk_eq("presc_count", int'(count), PRE_ON ? (i / PRESCALE) : (i % (MAX + 1)));
        end

        // Mid-operation reset
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        run(SC, 1'b1, 1'b0);
        chk_eq("mid_pre", int'(count), 8);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk_eq("mid_rst", int'(count), 0);
        run(SC - 1, 1'b1, 1'b0);
        chk_eq("mid_hold", int'(count), 0);
        run(1, 1'b1, 1'b0);
        chk_eq("mid_resume", int'(count), 1);

        // Random traffic through the scoreboard
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7),
                1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                4'($urandom_range(0, 15)));
        end

        chk_eq("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
